// File: rtl/change_dispenser.sv
// Ticket/coin dispenser: ejects tickets then greedy 10/5/1 change over 4-phase req/ack handshakes.
// Optional ack watchdog enabled by defining CHANGE_TIMEOUT_EN.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  tickets,
  input  logic [7:0]  change,
  input  logic [2:0]  hop_empty,
  input  logic        clr,
  output logic        tkt_req,
  input  logic        tkt_ack,
  output logic        coin_req,
  output logic [1:0]  coin_sel,
  input  logic        coin_ack,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [3:0]  rem_tkt,
  output logic [7:0]  rem_change,
  output logic [11:0] rem_bcd
);

  typedef enum logic [2:0] {
    S_IDLE, S_TKT_REQ, S_TKT_REL, S_COIN_SEL, S_COIN_REQ, S_COIN_REL, S_DONE, S_FAULT
  } state_t;

  state_t      r_state;
  logic [3:0]  w_tkt_clamp;
  logic [1:0]  w_sel;
  logic [7:0]  w_cur_val;
  logic        w_timeout;

  assign w_tkt_clamp = (tickets > 4'd9) ? 4'd9 : tickets;

  // Greedy pick with fallback to smaller coins when a hopper is empty.
  always_comb begin
    w_sel = 2'b00;
    if (rem_change >= 8'd10 && !hop_empty[2])     w_sel = 2'b11;
    else if (rem_change >= 8'd5 && !hop_empty[1]) w_sel = 2'b10;
    else if (!hop_empty[0])                       w_sel = 2'b01;
  end

  always_comb begin
    case (coin_sel)
      2'b11:   w_cur_val = 8'd10;
      2'b10:   w_cur_val = 8'd5;
      2'b01:   w_cur_val = 8'd1;
      default: w_cur_val = 8'd0;
    endcase
  end

  assign rem_bcd = {4'(rem_change / 8'd100), 4'((rem_change / 8'd10) % 8'd10), 4'(rem_change % 8'd10)};

`ifdef CHANGE_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] r_timer;
  logic          w_hs_wait;

  // True while a handshake state is still waiting for its ack edge; drops on every state change.
  assign w_hs_wait = (r_state == S_TKT_REQ  && !tkt_ack)  || (r_state == S_TKT_REL  && tkt_ack) ||
                     (r_state == S_COIN_REQ && !coin_ack) || (r_state == S_COIN_REL && coin_ack);
  assign w_timeout = w_hs_wait && (r_timer == TW'(ACK_TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst || !w_hs_wait) r_timer <= '0;
    else                    r_timer <= r_timer + TW'(1);
  end
`else
  assign w_timeout = 1'b0 && (ACK_TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      tkt_req    <= 1'b0;
      coin_req   <= 1'b0;
      coin_sel   <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      rem_tkt    <= '0;
      rem_change <= '0;
    end else begin
      done <= 1'b0;
      if (w_timeout) begin
        r_state  <= S_FAULT;
        tkt_req  <= 1'b0;
        coin_req <= 1'b0;
        coin_sel <= 2'b00;
        busy     <= 1'b0;
        fault    <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            rem_tkt    <= w_tkt_clamp;
            rem_change <= change;
            busy       <= 1'b1;
            if (w_tkt_clamp != 4'd0) begin
              tkt_req <= 1'b1;
              r_state <= S_TKT_REQ;
            end else begin
              r_state <= S_COIN_SEL;
            end
          end
          S_TKT_REQ: if (tkt_ack) begin
            tkt_req <= 1'b0;
            rem_tkt <= rem_tkt - 4'd1;
            r_state <= S_TKT_REL;
          end
          S_TKT_REL: if (!tkt_ack) begin
            if (rem_tkt != 4'd0) begin
              tkt_req <= 1'b1;
              r_state <= S_TKT_REQ;
            end else begin
              r_state <= S_COIN_SEL;
            end
          end
          S_COIN_SEL: begin
            if (rem_change == 8'd0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else if (w_sel != 2'b00) begin
              coin_req <= 1'b1;
              coin_sel <= w_sel;
              r_state  <= S_COIN_REQ;
            end else begin
              // Shortfall stays in rem_change for the display.
              busy    <= 1'b0;
              fault   <= 1'b1;
              r_state <= S_FAULT;
            end
          end
          S_COIN_REQ: if (coin_ack) begin
            coin_req   <= 1'b0;
            coin_sel   <= 2'b00;
            rem_change <= rem_change - w_cur_val;
            r_state    <= S_COIN_REL;
          end
          S_COIN_REL: if (!coin_ack) r_state <= S_COIN_SEL;
          S_DONE: begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          S_FAULT: if (clr) begin
            fault      <= 1'b0;
            rem_tkt    <= '0;
            rem_change <= '0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: job table with coin scoreboard, plus timing, reset and timeout sequences.
module tb_change_dispenser;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, clr = 1'b0;
  logic        tkt_ack = 1'b0, coin_ack = 1'b0;
  logic [3:0]  tickets = '0;
  logic [7:0]  change = '0;
  logic [2:0]  hop_empty = '0;
  logic        tkt_req, coin_req, busy, done, fault;
  logic [1:0]  coin_sel;
  logic [3:0]  rem_tkt;
  logic [7:0]  rem_change;
  logic [11:0] rem_bcd;

  always #5 clk = ~clk;

  change_dispenser #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .tickets(tickets), .change(change),
    .hop_empty(hop_empty), .clr(clr), .tkt_req(tkt_req), .tkt_ack(tkt_ack),
    .coin_req(coin_req), .coin_sel(coin_sel), .coin_ack(coin_ack), .busy(busy),
    .done(done), .fault(fault), .rem_tkt(rem_tkt), .rem_change(rem_change), .rem_bcd(rem_bcd)
  );

  typedef struct {logic [1:0] sel; logic [7:0] rem;} coin_t;
  typedef struct {logic [3:0] tkt; logic [7:0] chg; logic [2:0] he; int n_tkt; bit flt; logic [7:0] rem;} vec_t;

  coin_t sb[$];
  int    checks = 0, errors = 0, tkt_cnt = 0;
  bit    ack_en = 1'b1, saw_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within cycle budget", nm);
  endtask

  function automatic logic [11:0] bcd(input logic [7:0] v);
    int x = int'(v);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  // Expected coin sequence: greedy 10/5/1, skipping empty hoppers.
  task automatic push_model(input logic [7:0] chg, input logic [2:0] he);
    int v = int'(chg);
    coin_t c;
    while (v > 0) begin
      if (v >= 10 && !he[2])     c.sel = 2'b11;
      else if (v >= 5 && !he[1]) c.sel = 2'b10;
      else if (!he[0])           c.sel = 2'b01;
      else break;
      c.rem = 8'(v);
      sb.push_back(c);
      v -= (c.sel == 2'b11) ? 10 : (c.sel == 2'b10) ? 5 : 1;
    end
  endtask

  // Ejector/hopper model: acks follow reqs one cycle later; each new coin request is scored.
  initial begin
    coin_t c;
    forever begin
      @(posedge clk); #1;
      if (tkt_req || coin_req) saw_req = 1'b1;
      if (!ack_en) begin
        tkt_ack  = 1'b0;
        coin_ack = 1'b0;
      end else begin
        if (tkt_req && !tkt_ack) tkt_cnt++;
        if (coin_req && !coin_ack) begin
          if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL coin_unexpected: got sel %0d expected no coin", coin_sel);
          end else begin
            c = sb.pop_front();
            chk("coin_sel", 32'(coin_sel), 32'(c.sel));
            chk("coin_rem", 32'(rem_change), 32'(c.rem));
            chk("coin_bcd", 32'(rem_bcd), 32'(bcd(c.rem)));
          end
        end
        tkt_ack  = tkt_req;
        coin_ack = coin_req;
      end
    end
  end

  task automatic pulse_start(input logic [3:0] t, input logic [7:0] c, input logic [2:0] he);
    @(negedge clk);
    tickets = t; change = c; hop_empty = he; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int cyc = 0;
    while (!done && !fault && cyc < 2000) begin @(negedge clk); cyc++; end
    if (cyc >= 2000) fail(nm);
  endtask

  task automatic wait_coin_req(input string nm);
    int cyc = 0;
    while (!coin_req && cyc < 50) begin @(negedge clk); cyc++; end
    if (cyc >= 50) fail(nm);
  endtask

  task automatic run_job(input vec_t v);
    logic [3:0] clamp;
    clamp   = (v.tkt > 4'd9) ? 4'd9 : v.tkt;
    tkt_cnt = 0;
    push_model(v.chg, v.he);
    pulse_start(v.tkt, v.chg, v.he);
    chk("busy_start", 32'(busy), 1);
    chk("rem_tkt_load", 32'(rem_tkt), 32'(clamp));
    chk("rem_chg_load", 32'(rem_change), 32'(v.chg));
    chk("tkt_req_start", 32'(tkt_req), 32'(clamp != 4'd0));
    wait_end("job_end");
    chk("fault", 32'(fault), 32'(v.flt));
    chk("rem_end", 32'(rem_change), 32'(v.rem));
    chk("tkt_count", 32'(tkt_cnt), 32'(v.n_tkt));
    chk("coins_left", 32'(sb.size()), 0);
    if (v.flt) begin
      chk("fault_bcd", 32'(rem_bcd), 32'(bcd(v.rem)));
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_fault", 32'(fault), 0);
      chk("clr_rem", 32'({rem_tkt, rem_change}), 0);
      sb.delete();
    end else begin
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
      chk("busy_end", 32'(busy), 0);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 32'({tkt_req, coin_req, coin_sel, busy, done, fault, rem_tkt, rem_change, rem_bcd}), 0);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{4'd2,  8'd17,  3'b000, 2, 1'b0, 8'd0};
    vt[1] = '{4'd0,  8'd0,   3'b000, 0, 1'b0, 8'd0};
    vt[2] = '{4'd0,  8'd13,  3'b100, 0, 1'b0, 8'd0};
    vt[3] = '{4'd0,  8'd3,   3'b001, 0, 1'b1, 8'd3};
    vt[4] = '{4'd12, 8'd0,   3'b000, 9, 1'b0, 8'd0};
    vt[5] = '{4'd1,  8'd255, 3'b000, 1, 1'b0, 8'd0};
    vt[6] = '{4'd0,  8'd9,   3'b010, 0, 1'b0, 8'd0};
    vt[7] = '{4'd3,  8'd27,  3'b011, 3, 1'b1, 8'd7};
    vt[8] = '{4'd0,  8'd4,   3'b110, 0, 1'b0, 8'd0};

    repeat (2) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_job(vt[i]);

    // Empty job: done at N+2, busy low at N+3, no request ever.
    saw_req = 1'b0;
    pulse_start(4'd0, 8'd0, 3'b000);
    chk("empty_busy_n1", 32'(busy), 1);
    chk("empty_done_n1", 32'(done), 0);
    @(negedge clk);
    chk("empty_done_n2", 32'(done), 1);
    @(negedge clk);
    chk("empty_busy_n3", 32'({busy, done}), 0);
    chk("empty_no_req", 32'(saw_req), 0);

    // Zero-ticket job: first coin request at N+2.
    push_model(8'd1, 3'b000);
    pulse_start(4'd0, 8'd1, 3'b000);
    chk("coin_req_n1", 32'(coin_req), 0);
    @(negedge clk);
    chk("coin_req_n2", 32'({coin_req, coin_sel}), 32'(3'b101));
    wait_end("one_coin_end");
    chk("one_coin_left", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);

    // A second start mid-job is ignored.
    tkt_cnt = 0;
    push_model(8'd20, 3'b000);
    pulse_start(4'd0, 8'd20, 3'b000);
    repeat (2) @(negedge clk);
    pulse_start(4'd5, 8'd99, 3'b000);
    wait_end("restart_end");
    chk("restart_tkts", 32'(tkt_cnt), 0);
    chk("restart_coins_left", 32'(sb.size()), 0);
    chk("restart_rem", 32'(rem_change), 0);
    repeat (2) @(negedge clk);

    // Reset while a coin request is outstanding.
    ack_en = 1'b0;
    pulse_start(4'd0, 8'd5, 3'b000);
    wait_coin_req("rst_wait_req");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid_coin");
    rst = 1'b1;
    @(negedge clk);

    // Coin ack never returns.
    pulse_start(4'd0, 8'd10, 3'b000);
    wait_coin_req("to_wait_req");
`ifdef CHANGE_TIMEOUT_EN
    repeat (8) @(negedge clk);
    chk("to_fault_early", 32'(fault), 0);
    @(negedge clk);
    chk("to_fault", 32'(fault), 1);
    chk("to_coin_req", 32'(coin_req), 0);
    chk("to_rem", 32'(rem_change), 10);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("to_clr", 32'({fault, rem_change}), 0);
`else
    repeat (40) @(negedge clk);
    chk("wait_coin_req", 32'(coin_req), 1);
    chk("wait_no_fault", 32'(fault), 0);
    chk("wait_rem", 32'(rem_change), 10);
`endif
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
